// File: rtl/multdiv_issue_ctrl_if.sv
// Issue/unit/writeback bundle for the mult/div sequencer.
// master = sequencer side, slave = pipeline + unit side.
interface multdiv_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              issue_valid;
  logic              issue_op;
  logic [REG_W-1:0]  issue_rd;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic              issue_ready;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] md_operandA;
  logic [DATA_W-1:0] md_operandB;
  logic              md_ctrl_MULT;
  logic              md_ctrl_DIV;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exception;
  logic              wb_timeout;
  logic              wb_ack;

  modport master (
    input  issue_valid, issue_op, issue_rd,
    input  issue_a, issue_b, flush,
    input  md_result, md_exception, md_resultRDY,
    input  wb_ack,
    output issue_ready, stall,
    output md_operandA, md_operandB,
    output md_ctrl_MULT, md_ctrl_DIV,
    output wb_valid, wb_rd, wb_data,
    output wb_exception, wb_timeout
  );

  modport slave (
    output issue_valid, issue_op, issue_rd,
    output issue_a, issue_b, flush,
    output md_result, md_exception, md_resultRDY,
    output wb_ack,
    input  issue_ready, stall,
    input  md_operandA, md_operandB,
    input  md_ctrl_MULT, md_ctrl_DIV,
    input  wb_valid, wb_rd, wb_data,
    input  wb_exception, wb_timeout
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Sequencer between execute and the iterative mult/div unit.
// One op in flight; start pulse, wait, capture, writeback handshake.
module multdiv_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int LATENCY = 33,
  parameter int TIMEOUT = 40
) (
  input logic                 clk,
  input logic                 rst_n,
  multdiv_issue_ctrl_if.master bus
);

  localparam int CNT_MAX =
    (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam int I_IDLE  = 0;
  localparam int I_START = 1;
  localparam int I_BUSY  = 2;
  localparam int I_DONE  = 3;
  localparam int I_DRAIN = 4;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_START = 5'b00010;
  localparam logic [4:0] S_BUSY  = 5'b00100;
  localparam logic [4:0] S_DONE  = 5'b01000;
  localparam logic [4:0] S_DRAIN = 5'b10000;

  logic [4:0]        state;
  logic              op_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] data_q;
  logic              exc_q;
  logic              to_q;

  logic rdy;
  logic last;
  logic div_zero;

  assign rdy      = bus.md_resultRDY;
  assign last     = (cnt == CNT_LAST);
  assign div_zero = op_q & bus.md_exception;

  // Sequencer state, latched op and captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= 1'b0;
      rd_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      data_q <= '0;
      exc_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        state[I_IDLE]: begin
          if (bus.issue_valid && !bus.flush) begin
            op_q  <= bus.issue_op;
            rd_q  <= bus.issue_rd;
            a_q   <= bus.issue_a;
            b_q   <= bus.issue_b;
            state <= S_START;
          end
        end
        state[I_START]: begin
          cnt   <= '0;
          state <= bus.flush ? S_DRAIN : S_BUSY;
        end
        state[I_BUSY]: begin
          if (rdy || last) begin
            data_q <= (rdy && !div_zero) ?
                      bus.md_result : '0;
            exc_q  <= rdy ? div_zero : 1'b1;
            to_q   <= ~rdy;
            state  <= bus.flush ? S_IDLE : S_DONE;
          end else begin
            cnt   <= cnt + CNT_ONE;
            state <= bus.flush ? S_DRAIN : S_BUSY;
          end
        end
        state[I_DONE]: begin
          if (bus.flush || bus.wb_ack)
            state <= S_IDLE;
        end
        state[I_DRAIN]: begin
          if (rdy || last)
            state <= S_IDLE;
          else
            cnt <= cnt + CNT_ONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.issue_ready  = state[I_IDLE];
  assign bus.stall        = ~state[I_IDLE];
  assign bus.md_operandA  = a_q;
  assign bus.md_operandB  = b_q;
  assign bus.md_ctrl_MULT = state[I_START] & ~op_q;
  assign bus.md_ctrl_DIV  = state[I_START] & op_q;
  assign bus.wb_valid     = state[I_DONE];
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = data_q;
  assign bus.wb_exception = exc_q;
  assign bus.wb_timeout   = to_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: unit stub, op-level model,
// directed corner cases and a randomized run.
module tb_multdiv_issue_ctrl;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int LATENCY = 33;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multdiv_issue_ctrl_if #(
    .DATA_W(DATA_W), .REG_W(REG_W)
  ) bus ();

  multdiv_issue_ctrl #(
    .DATA_W(DATA_W), .REG_W(REG_W),
    .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(
    input bit op, input logic [31:0] a,
    input logic [31:0] b);
    if (!op) return a * b;
    if (b == 32'd0) return 32'd0;
    return $signed(a) / $signed(b);
  endfunction

  // Op-level reference model: one op, its age in
  // cycles since acceptance, and its outcome.
  bit          m_has, m_fin, m_drop, m_op;
  int          m_age;
  logic [4:0]  m_rd;
  logic [31:0] m_a, m_b, m_data;
  bit          m_exc, m_to;
  logic        m_got, m_tmo, m_drop_now;

  assign m_got      = bus.md_resultRDY;
  assign m_tmo      = (m_age == TIMEOUT + 1);
  assign m_drop_now = m_drop | bus.flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_has <= 0; m_fin <= 0; m_drop <= 0;
      m_op <= 0; m_age <= 0; m_rd <= '0;
      m_a <= '0; m_b <= '0; m_data <= '0;
      m_exc <= 0; m_to <= 0;
    end else if (!m_has) begin
      if (bus.issue_valid && !bus.flush) begin
        m_has <= 1; m_fin <= 0; m_drop <= 0;
        m_age <= 1; m_op <= bus.issue_op;
        m_rd <= bus.issue_rd;
        m_a <= bus.issue_a; m_b <= bus.issue_b;
      end
    end else if (m_fin) begin
      if (bus.flush || bus.wb_ack) m_has <= 0;
    end else if (m_age == 1) begin
      m_drop <= m_drop_now;
      m_age  <= 2;
    end else if (m_got || m_tmo) begin
      if (m_drop_now) m_has <= 0;
      else begin
        m_fin <= 1;
        if (m_got) begin
          m_data <= exp_data(m_op, m_a, m_b);
          m_exc  <= m_op && (m_b == 32'd0);
          m_to   <= 0;
        end else begin
          m_data <= '0; m_exc <= 1; m_to <= 1;
        end
      end
    end else begin
      m_age  <= m_age + 1;
      m_drop <= m_drop_now;
    end
  end

  // Compare process: every cycle, away from the edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("issue_ready", 64'(bus.issue_ready),
            64'(!m_has));
      check("stall", 64'(bus.stall), 64'(m_has));
      check("md_ctrl_MULT", 64'(bus.md_ctrl_MULT),
            64'(m_has && !m_fin && m_age == 1 && !m_op));
      check("md_ctrl_DIV", 64'(bus.md_ctrl_DIV),
            64'(m_has && !m_fin && m_age == 1 && m_op));
      check("wb_valid", 64'(bus.wb_valid),
            64'(m_has && m_fin));
      if (m_has && !m_fin) begin
        check("md_operandA", 64'(bus.md_operandA),
              64'(m_a));
        check("md_operandB", 64'(bus.md_operandB),
              64'(m_b));
      end
      if (m_has && m_fin) begin
        check("wb_rd", 64'(bus.wb_rd), 64'(m_rd));
        check("wb_data", 64'(bus.wb_data),
              64'(m_data));
        check("wb_exception", 64'(bus.wb_exception),
              64'(m_exc));
        check("wb_timeout", 64'(bus.wb_timeout),
              64'(m_to));
      end
    end
  end

  // Unit stub: LATENCY + u_extra cycles after a
  // sampled start, one-cycle ready; optional spurious.
  bit          u_active;
  int          u_left;
  int          u_extra = 0;
  bit          spur_en = 0;
  logic [31:0] u_res;
  bit          u_exc;
  bit          u_spur;

  initial begin
    u_active = 0; u_left = 0;
    u_res = '0; u_exc = 0;
    bus.md_resultRDY = 1'b0;
    bus.md_result = '0;
    bus.md_exception = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) u_active = 0;
      else begin
        if (u_active) begin
          u_left--;
          if (u_left == 0) u_active = 0;
        end
        if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
          check("start_unit_idle", 64'(u_active), 64'(0));
          u_active = 1;
          u_left = LATENCY + u_extra;
          if (bus.md_ctrl_DIV) begin
            u_exc = (bus.md_operandB == 32'd0);
            u_res = u_exc ? 32'hDEADBEEF :
              exp_data(1'b1, bus.md_operandA,
                       bus.md_operandB);
          end else begin
            u_exc = 1'($urandom_range(0, 1));
            u_res = bus.md_operandA * bus.md_operandB;
          end
        end
      end
      #1;
      u_spur = !u_active && spur_en &&
               ($urandom_range(0, 15) == 0);
      if (u_active && u_left == 1) begin
        bus.md_resultRDY = 1'b1;
        bus.md_result = u_res;
        bus.md_exception = u_exc;
      end else begin
        bus.md_resultRDY = u_spur;
        bus.md_result = $urandom;
        bus.md_exception = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_unit_idle();
    int k = 0;
    while (u_active && k < 300) begin
      tick(); k++;
    end
    if (u_active) check("unit_idle_wait", 64'(1), 64'(0));
  endtask

  task automatic drive_issue(input bit op,
                             input logic [4:0] rd,
                             input logic [31:0] a,
                             input logic [31:0] b);
    bus.issue_valid = 1'b1;
    bus.issue_op = op;
    bus.issue_rd = rd;
    bus.issue_a = a;
    bus.issue_b = b;
  endtask

  // Issue one op and wait for wb_valid; n counts
  // cycles from the handshake edge.
  task automatic do_op(input bit op,
                       input logic [4:0] rd,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int extra,
                       output int n, output int pm,
                       output int pd);
    wait_unit_idle();
    u_extra = extra;
    drive_issue(op, rd, a, b);
    tick();
    bus.issue_valid = 1'b0;
    n = 0; pm = 0; pd = 0;
    while (!bus.wb_valid && n < 200) begin
      pm += int'(bus.md_ctrl_MULT);
      pd += int'(bus.md_ctrl_DIV);
      tick(); n++;
    end
    if (!bus.wb_valid) check("wb_valid_wait", 64'(0), 64'(1));
  endtask

  task automatic ack_it();
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    check("ready_after_ack", 64'(bus.issue_ready), 64'(1));
    check("valid_after_ack", 64'(bus.wb_valid), 64'(0));
  endtask

  int n, pm, pd, rdy_n, vcnt;
  logic [31:0] ra, rb;

  initial begin
    bus.issue_valid = 1'b0; bus.issue_op = 1'b0;
    bus.issue_rd = '0; bus.issue_a = '0;
    bus.issue_b = '0; bus.flush = 1'b0;
    bus.wb_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_issue_ready", 64'(bus.issue_ready), 64'(1));
    check("rst_stall", 64'(bus.stall), 64'(0));
    check("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("rst_ctrl", 64'({bus.md_ctrl_MULT,
          bus.md_ctrl_DIV}), 64'(0));
    check("rst_operands", 64'({bus.md_operandA,
          bus.md_operandB}), 64'(0));
    check("rst_wb", 64'({bus.wb_rd, bus.wb_data,
          bus.wb_exception, bus.wb_timeout}), 64'(0));
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // MULT 7 * -3
    do_op(1'b0, 5'd3, 32'd7, 32'hFFFFFFFD, 0, n, pm, pd);
    check("mul_latency", 64'(n), 64'(34));
    check("mul_pulses", 64'(pm), 64'(1));
    check("mul_no_div", 64'(pd), 64'(0));
    check("mul_data", 64'(bus.wb_data), 64'(32'hFFFFFFEB));
    check("mul_exc", 64'(bus.wb_exception), 64'(0));
    check("mul_rd", 64'(bus.wb_rd), 64'(3));
    ack_it();

    // DIV 100 / -7
    do_op(1'b1, 5'd9, 32'd100, 32'hFFFFFFF9, 0, n, pm, pd);
    check("div_latency", 64'(n), 64'(34));
    check("div_pulses", 64'(pd), 64'(1));
    check("div_data", 64'(bus.wb_data), 64'(32'hFFFFFFF2));
    check("div_exc", 64'(bus.wb_exception), 64'(0));
    ack_it();

    // DIV 5 / 0, then hold ack off for 10 cycles
    do_op(1'b1, 5'd4, 32'd5, 32'd0, 0, n, pm, pd);
    check("dz_data", 64'(bus.wb_data), 64'(0));
    check("dz_exc", 64'(bus.wb_exception), 64'(1));
    check("dz_timeout", 64'(bus.wb_timeout), 64'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_stall", 64'(bus.stall), 64'(1));
      check("hold_ready", 64'(bus.issue_ready), 64'(0));
      check("hold_valid", 64'(bus.wb_valid), 64'(1));
      check("hold_data", 64'({bus.wb_data,
            bus.wb_exception}), 64'(1));
    end
    ack_it();

    // Flush 10 cycles into BUSY
    wait_unit_idle();
    u_extra = 0;
    drive_issue(1'b1, 5'd7, 32'd1000, 32'd3);
    tick();
    bus.issue_valid = 1'b0;
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n = 0; rdy_n = -100; vcnt = 0;
    while (!bus.issue_ready && n < 100) begin
      if (bus.md_resultRDY) rdy_n = n;
      vcnt += int'(bus.wb_valid);
      tick(); n++;
    end
    check("flush_ready_after_rdy", 64'(n), 64'(rdy_n + 1));
    check("flush_no_valid", 64'(vcnt), 64'(0));

    // Flush in IDLE beats a same-cycle issue
    drive_issue(1'b0, 5'd1, 32'd2, 32'd2);
    bus.flush = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    bus.flush = 1'b0;
    check("idle_flush_no_accept", 64'(bus.stall), 64'(0));

    // Unit never answers in time: timeout
    do_op(1'b0, 5'd12, 32'd2, 32'd3, 60, n, pm, pd);
    check("to_latency", 64'(n), 64'(41));
    check("to_data", 64'(bus.wb_data), 64'(0));
    check("to_exc", 64'(bus.wb_exception), 64'(1));
    check("to_flag", 64'(bus.wb_timeout), 64'(1));
    ack_it();

    // Result and timeout on the same edge
    do_op(1'b0, 5'd13, 32'd6, 32'd7, 7, n, pm, pd);
    check("race_latency", 64'(n), 64'(41));
    check("race_data", 64'(bus.wb_data), 64'(42));
    check("race_flag", 64'(bus.wb_timeout), 64'(0));
    ack_it();

    // Randomized run
    wait_unit_idle();
    spur_en = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      bus.flush = ($urandom_range(0, 49) == 0);
      bus.wb_ack = ($urandom_range(0, 2) != 0);
      bus.issue_valid = 1'b0;
      if (!u_active && $urandom_range(0, 3) == 0) begin
        ra = $urandom;
        rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
             ($urandom_range(0, 1) == 0) ? $urandom :
             32'($urandom_range(1, 50));
        if (ra == 32'h80000000 && rb == 32'hFFFFFFFF)
          rb = 32'd1;
        case ($urandom_range(0, 7))
          5: u_extra = 7;
          6: u_extra = 8;
          7: u_extra = 20;
          default: u_extra = 0;
        endcase
        drive_issue(1'($urandom_range(0, 1)),
                    5'($urandom), ra, rb);
      end
      tick();
    end
    bus.issue_valid = 1'b0;
    bus.flush = 1'b0;
    bus.wb_ack = 1'b1;
    spur_en = 1'b0;
    wait_unit_idle();
    repeat (4) tick();
    check("end_idle", 64'(bus.issue_ready), 64'(1));
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
